// File: rtl/cmd_assembler_if.sv
// Bundle of the receive, command and transmit handshakes around cmd_assembler.
// master drives the UART/command-processor side; slave is the assembler itself.
interface cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        resp_vld;
  logic [7:0]  resp;
  logic        tx_busy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        frm_err;
  logic        resp_drop;

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp_vld, resp, tx_busy,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, frm_err, resp_drop
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp_vld, resp, tx_busy,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, frm_err, resp_drop
  );
endinterface

// File: rtl/cmd_assembler.sv
// Packs two UART bytes into a 16-bit command and paces response bytes to the
// transmitter through a one-entry buffer. Optional macro: CMD_TIMEOUT_EN.
//
// state | meaning
// HIGH  | await high byte
// LOW   | await low byte
// FULL  | cmd held, cmd_rdy asserted
module cmd_assembler #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input logic            clk,
  input logic            rst,
  cmd_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    HIGH = 2'd0,
    LOW  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_rx_rdy;

  logic [7:0]  rbuf_q, rbuf_d;
  logic        rbuf_vld_q, rbuf_vld_d;
  logic        trmt_q, trmt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        resp_drop_q, resp_drop_d;
  logic        can_issue;

`ifdef CMD_TIMEOUT_EN
  logic [19:0] tmo_cnt_q, tmo_cnt_d;
  logic        frm_err_q, frm_err_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 20'd1);
`else
  logic        unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    clr_rx_rdy = 1'b0;
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    frm_err_d  = 1'b0;
`endif
    unique case (state_q)
      HIGH: begin
        if (bus.rx_rdy) begin
          clr_rx_rdy = 1'b1;
          high_d     = bus.rx_data;
          state_d    = LOW;
`ifdef CMD_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      LOW: begin
        // A byte in the terminal-count cycle still wins over the timeout
        if (bus.rx_rdy) begin
          clr_rx_rdy = 1'b1;
          cmd_d      = {high_q, bus.rx_data};
          cmd_rdy_d  = 1'b1;
          state_d    = FULL;
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = HIGH;
          frm_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
`endif
      end
      FULL: begin
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = HIGH;
        end
      end
      default: state_d = HIGH;
    endcase
    if (rst) clr_rx_rdy = 1'b0;
  end

  // trmt_q blocks back-to-back issue until the transmitter raises tx_busy
  always_comb begin
    can_issue   = !bus.tx_busy && !trmt_q;
    rbuf_d      = rbuf_q;
    rbuf_vld_d  = rbuf_vld_q;
    trmt_d      = 1'b0;
    tx_data_d   = tx_data_q;
    resp_drop_d = 1'b0;
    if (rbuf_vld_q) begin
      if (can_issue) begin
        trmt_d     = 1'b1;
        tx_data_d  = rbuf_q;
        rbuf_vld_d = bus.resp_vld;
        if (bus.resp_vld) rbuf_d = bus.resp;
      end else if (bus.resp_vld) begin
        resp_drop_d = 1'b1;
      end
    end else if (bus.resp_vld) begin
      if (can_issue) begin
        trmt_d    = 1'b1;
        tx_data_d = bus.resp;
      end else begin
        rbuf_d     = bus.resp;
        rbuf_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HIGH;
      high_q      <= 8'h00;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      rbuf_q      <= 8'h00;
      rbuf_vld_q  <= 1'b0;
      trmt_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      resp_drop_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      frm_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      rbuf_q      <= rbuf_d;
      rbuf_vld_q  <= rbuf_vld_d;
      trmt_q      <= trmt_d;
      tx_data_q   <= tx_data_d;
      resp_drop_q <= resp_drop_d;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      frm_err_q   <= frm_err_d;
`endif
    end
  end

  assign bus.clr_rx_rdy = clr_rx_rdy;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.resp_drop  = resp_drop_q;
`ifdef CMD_TIMEOUT_EN
  assign bus.frm_err    = frm_err_q;
`else
  assign bus.frm_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed bench for cmd_assembler: a vector table for single-cycle behaviour plus
// hand sequences for reset-mid-command and the low-byte timeout.
module tb_cmd_assembler;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  cmd_assembler_if bus_if ();

  cmd_assembler #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_cmd_rdy;
    logic        resp_vld;
    logic [7:0]  resp;
    logic        tx_busy;
    logic        e_clr;
    logic [15:0] e_cmd;
    logic        e_cmd_rdy;
    logic        e_trmt;
    logic [7:0]  e_tx_data;
    logic        e_drop;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.rx_rdy      = 1'b0;
    bus_if.rx_data     = 8'h00;
    bus_if.clr_cmd_rdy = 1'b0;
    bus_if.resp_vld    = 1'b0;
    bus_if.resp        = 8'h00;
    bus_if.tx_busy     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = b;
    #1;
    check($sformatf("accept %h clr_rx_rdy", b), 16'(bus_if.clr_rx_rdy), 16'h1);
    step();
    bus_if.rx_rdy  = 1'b0;
    bus_if.rx_data = 8'h00;
  endtask

  task automatic release_cmd();
    bus_if.clr_cmd_rdy = 1'b1;
    step();
    bus_if.clr_cmd_rdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd"},        bus_if.cmd,              16'h0000);
    check({tag, " cmd_rdy"},    16'(bus_if.cmd_rdy),     16'h0);
    check({tag, " trmt"},       16'(bus_if.trmt),        16'h0);
    check({tag, " tx_data"},    16'(bus_if.tx_data),     16'h00);
    check({tag, " resp_drop"},  16'(bus_if.resp_drop),   16'h0);
    check({tag, " frm_err"},    16'(bus_if.frm_err),     16'h0);
    check({tag, " clr_rx_rdy"}, 16'(bus_if.clr_rx_rdy),  16'h0);
  endtask

  initial begin
    //          rx  data   ccr   vld   resp   busy | clr  cmd       rdy   trmt  txd    drop
    vecs[0]  = '{1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h417F, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h417F, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h417F, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h417F, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h417F, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[25] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'h22, 1'b0};

    // Reset with a byte pending: nothing may be consumed while rst is high
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = 8'h99;
    #1;
    check_reset_outputs("reset");
    bus_if.rx_rdy  = 1'b0;
    bus_if.rx_data = 8'h00;
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      bus_if.rx_rdy      = vecs[i].rx_rdy;
      bus_if.rx_data     = vecs[i].rx_data;
      bus_if.clr_cmd_rdy = vecs[i].clr_cmd_rdy;
      bus_if.resp_vld    = vecs[i].resp_vld;
      bus_if.resp        = vecs[i].resp;
      bus_if.tx_busy     = vecs[i].tx_busy;
      #1;
      check($sformatf("v%0d clr_rx_rdy", i), 16'(bus_if.clr_rx_rdy), 16'(vecs[i].e_clr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d cmd", i),       bus_if.cmd,             vecs[i].e_cmd);
      check($sformatf("v%0d cmd_rdy", i),   16'(bus_if.cmd_rdy),    16'(vecs[i].e_cmd_rdy));
      check($sformatf("v%0d trmt", i),      16'(bus_if.trmt),       16'(vecs[i].e_trmt));
      check($sformatf("v%0d tx_data", i),   16'(bus_if.tx_data),    16'(vecs[i].e_tx_data));
      check($sformatf("v%0d resp_drop", i), 16'(bus_if.resp_drop),  16'(vecs[i].e_drop));
      check($sformatf("v%0d frm_err", i),   16'(bus_if.frm_err),    16'h0);
    end
    idle_inputs();
    step();

    // Reset while waiting for the low byte, then a fresh command
    send_byte(8'h20);
    rst = 1'b1;
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = 8'h77;
    step();
    check_reset_outputs("rst_in_low");
    bus_if.rx_rdy  = 1'b0;
    bus_if.rx_data = 8'h00;
    rst = 1'b0;
    step();
    send_byte(8'h11);
    send_byte(8'h22);
    check("after_rst cmd",     bus_if.cmd,          16'h1122);
    check("after_rst cmd_rdy", 16'(bus_if.cmd_rdy), 16'h1);
    release_cmd();

`ifdef CMD_TIMEOUT_EN
    begin
      int seen;
      int errs;
      seen = 0;
      errs = 0;
      send_byte(8'h3C);
      for (int k = 1; k <= 20; k++) begin
        if (bus_if.frm_err) begin
          errs++;
          if (seen == 0) seen = k;
        end
        step();
      end
      check("timeout frm_err cycle", 16'(seen), 16'd17);
      check("timeout frm_err pulses", 16'(errs), 16'd1);
      send_byte(8'h40);
      send_byte(8'h01);
      check("post_timeout cmd",     bus_if.cmd,          16'h4001);
      check("post_timeout cmd_rdy", 16'(bus_if.cmd_rdy), 16'h1);
      release_cmd();

      // Low byte lands exactly on the terminal count
      send_byte(8'h55);
      for (int k = 0; k < 15; k++) step();
      send_byte(8'h66);
      check("edge cmd",     bus_if.cmd,          16'h5566);
      check("edge cmd_rdy", 16'(bus_if.cmd_rdy), 16'h1);
      check("edge frm_err", 16'(bus_if.frm_err), 16'h0);
      release_cmd();
    end
`else
    begin
      int errs;
      errs = 0;
      send_byte(8'h3C);
      for (int k = 0; k < 40; k++) begin
        if (bus_if.frm_err) errs++;
        step();
      end
      check("no_timeout frm_err", 16'(errs), 16'd0);
      send_byte(8'h01);
      check("no_timeout cmd",     bus_if.cmd,          16'h3C01);
      check("no_timeout cmd_rdy", 16'(bus_if.cmd_rdy), 16'h1);
      release_cmd();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
